lfsr_add_pipeline: RTL and testbench

Parametrised successor to the combinational LFSR-driven adder chain: a WIDTH-bit Fibonacci LFSR feeds an N-stage registered add/subtract pipeline with per-stage valid/ready flow control. The pipeline output drains through a ready/valid port into a running checksum and a handshake counter. It is a self-stimulating datapath and backpressure test block for the simulator regression set.

---
 rtl/lfsr_chain_pkg.sv | 18 +
 rtl/chain_stage.sv | 43 ++++
 rtl/lfsr_add_pipeline.sv | 89 ++++++++
 tb/tb_lfsr_add_pipeline.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_chain_pkg.sv
// Shared types and constants for the LFSR-driven add/subtract pipeline.
package lfsr_chain_pkg;

  localparam int COUNT_W       = 16;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef struct packed {
    logic                     valid;
    mode_e                    mode;
    logic [DEFAULT_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/chain_stage.sv
// One register slice of the add/subtract chain with valid/ready flow control.
module chain_stage
  import lfsr_chain_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] addend,
  input  logic             down_ready,
  output logic             up_ready,
  output logic             valid,
  output logic             mode,
  output logic [WIDTH-1:0] data
);

  function automatic logic [WIDTH-1:0] apply_op(input logic m,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] k);
    return (mode_e'(m) == MODE_SUB) ? a - k : a + k;
  endfunction

  // A slot can take a new value when empty or when its contents move on this cycle.
  assign up_ready = !valid || down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      data  <= '0;
    end else if (up_ready) begin
      valid <= in_valid;
      if (in_valid) begin
        mode <= in_mode;
        data <= apply_op(in_mode, in_data, addend);
      end
    end
  end

endmodule

// File: rtl/lfsr_add_pipeline.sv
// Fibonacci LFSR feeding an N-stage add/subtract pipeline that drains into a
// running checksum and a saturating handshake counter.
module lfsr_add_pipeline
  import lfsr_chain_pkg::*;
#(
  parameter int          WIDTH = DEFAULT_WIDTH,
  parameter int          N     = 4,
  parameter logic [63:0] SEED  = 64'hA5,
  parameter logic [63:0] TAPS  = 64'hB8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   checksum,
  output logic [COUNT_W-1:0] count
);

  localparam logic [WIDTH-1:0] SEED_T = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TAPS_T = TAPS[WIDTH-1:0];

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end
  if (N < 1) begin : g_bad_n
    $error("N must be at least 1");
  end
  if (SEED_T == '0) begin : g_bad_seed
    $error("SEED truncated to WIDTH must be nonzero");
  end

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [WIDTH-1:0] lfsr;
  logic [N:0]       rdy;
  logic [N:0]       vld;
  logic [N:0]       md;
  logic [WIDTH-1:0] dat [0:N];

  // Index 0 is the injection point; index i+1 is the output of stage i.
  assign vld[0]  = en;
  assign md[0]   = mode;
  assign dat[0]  = lfsr;
  assign rdy[N]  = out_ready;

  for (genvar i = 0; i < N; i++) begin : g_stage
    chain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[i]),
      .in_mode   (md[i]),
      .in_data   (dat[i]),
      .addend    (WIDTH'(i + 1)),
      .down_ready(rdy[i+1]),
      .up_ready  (rdy[i]),
      .valid     (vld[i+1]),
      .mode      (md[i+1]),
      .data      (dat[i+1])
    );
  end

  assign out_valid = vld[N];
  assign result    = dat[N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED_T;
    end else if (en && rdy[0]) begin
      lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS_T)};
    end
  end

  // Drain side: one accumulation per accepted result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
      count    <= '0;
    end else if (out_valid && out_ready) begin
      checksum <= checksum + result;
      count    <= sat_inc(count);
    end
  end

endmodule

// File: tb/tb_lfsr_add_pipeline.sv
// Bench for lfsr_add_pipeline: directed vector table, corner-case sequences,
// randomized traffic against a token-level model, and a 4-bit/1-stage instance.
module tb_lfsr_add_pipeline;

  localparam int          W   = 8;
  localparam int          N   = 4;
  localparam logic [W-1:0] SUM = W'(N * (N + 1) / 2);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] result, checksum;
  logic [15:0]  count;

  logic         en4 = 1'b0, mode4 = 1'b0, ordy4 = 1'b0;
  logic         out_valid4;
  logic [3:0]   result4, checksum4;
  logic [15:0]  count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_add_pipeline #(.WIDTH(W), .N(N), .SEED(64'hA5), .TAPS(64'hB8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .out_ready(out_ready),
    .out_valid(out_valid), .result(result), .checksum(checksum), .count(count)
  );

  lfsr_add_pipeline #(.WIDTH(4), .N(1), .SEED(64'h1), .TAPS(64'hC)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .out_ready(ordy4),
    .out_valid(out_valid4), .result(result4), .checksum(checksum4), .count(count4)
  );

  // Token-level model: each slot holds the token's final end-to-end result.
  bit           mv   [N];
  logic [W-1:0] mval [N];
  logic [W-1:0] mlfsr;
  logic [W-1:0] mcs;
  logic [15:0]  mcnt;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      mval[i] = '0;
    end
    mlfsr = 8'hA5;
    mcs = '0;
    mcnt = '0;
  endtask

  task automatic model_step(input bit e, input bit m, input bit r);
    bit rd [N+1];
    rd[N] = r;
    for (int i = N - 1; i >= 0; i--) rd[i] = !mv[i] || rd[i+1];
    if (mv[N-1] && r) begin
      mcs = mcs + mval[N-1];
      if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    end
    for (int i = N - 1; i >= 1; i--) begin
      if (rd[i]) begin
        mv[i] = mv[i-1];
        if (mv[i-1]) mval[i] = mval[i-1];
      end
    end
    if (rd[0]) begin
      mv[0] = e;
      if (e) begin
        mval[0] = m ? mlfsr - SUM : mlfsr + SUM;
        mlfsr = {mlfsr[W-2:0], ^(mlfsr & 8'hB8)};
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_chk(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(mv[N-1]));
    if (mv[N-1]) chk({tag, "_result"}, 32'(result), 32'(mval[N-1]));
    chk({tag, "_checksum"}, 32'(checksum), 32'(mcs));
    chk({tag, "_count"}, 32'(count), 32'(mcnt));
  endtask

  task automatic cycle(input bit e, input bit m, input bit r);
    @(negedge clk);
    en = e;
    mode = m;
    out_ready = r;
    model_step(e, m, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    mode = 1'b0;
    out_ready = 1'b0;
    en4 = 1'b0;
    ordy4 = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_checksum", 32'(checksum), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit           rst_first;
    bit           en;
    bit           mode;
    bit           ordy;
    bit           exp_v;
    logic [W-1:0] exp_r;
    logic [W-1:0] exp_cs;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [3:0] l4;
    logic [3:0] res4 [32];
    bit         seen [16];
    int         distinct;
    logic [W-1:0] resume [3];
    bit         tog_v [10];
    logic [W-1:0] tog_r [10];

    // Streaming add from reset, then one subtract token followed by an add token.
    tbl[0]  = '{1, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[1]  = '{0, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[2]  = '{0, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[3]  = '{0, 1, 0, 1, 1, 8'hAF, 8'h00};
    tbl[4]  = '{0, 1, 0, 1, 1, 8'h54, 8'hAF};
    tbl[5]  = '{0, 1, 0, 1, 1, 8'h9F, 8'h03};
    tbl[6]  = '{0, 1, 0, 1, 1, 8'h34, 8'hA2};
    tbl[7]  = '{1, 1, 1, 1, 0, 8'h00, 8'h00};
    tbl[8]  = '{0, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[9]  = '{0, 1, 0, 1, 0, 8'h00, 8'h00};
    tbl[10] = '{0, 1, 0, 1, 1, 8'h9B, 8'h00};
    tbl[11] = '{0, 1, 0, 1, 1, 8'h54, 8'h9B};

    model_reset();
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst_first) do_reset();
      cycle(tbl[i].en, tbl[i].mode, tbl[i].ordy);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].exp_r));
      chk($sformatf("tbl%0d_checksum", i), 32'(checksum), 32'(tbl[i].exp_cs));
    end

    // Backpressure: fill with out_ready low, then resume.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      model_chk("stall");
      if (i >= 3) begin
        chk("stall_hold_valid", 32'(out_valid), 32'h1);
        chk("stall_hold_result", 32'(result), 32'hAF);
      end
    end
    resume = '{8'h54, 8'h9F, 8'h34};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      model_chk("resume");
      chk($sformatf("resume%0d", i), 32'(result), 32'(resume[i]));
    end

    // Asynchronous reset between edges, mid-stream.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_checksum", 32'(checksum), 32'h0);
    chk("async_count", 32'(count), 32'h0);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      model_chk("after_async");
    end
    chk("after_async_first", 32'(result), 32'hAF);

    // Enable toggling: bubbles pass through, LFSR advances only on en cycles.
    do_reset();
    tog_v = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0};
    tog_r = '{8'h00, 8'h00, 8'h00, 8'hAF, 8'h00, 8'h54, 8'h00, 8'h9F, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      cycle((i < 6) && (i % 2 == 0), 1'b0, 1'b1);
      model_chk("toggle");
      chk($sformatf("toggle%0d_valid", i), 32'(out_valid), 32'(tog_v[i]));
      if (tog_v[i]) chk($sformatf("toggle%0d_result", i), 32'(result), 32'(tog_r[i]));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0);
      model_chk("rand");
    end

    // 4-bit, single-stage instance: maximal-length sequence and wraparound.
    do_reset();
    @(negedge clk);
    en4 = 1'b1;
    ordy4 = 1'b1;
    l4 = 4'h1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      chk("w4_valid", 32'(out_valid4), 32'h1);
      chk("w4_result", 32'(result4), 32'(4'(l4 + 4'd1)));
      if (l4 == 4'hF) chk("w4_wrap", 32'(result4), 32'h0);
      res4[i] = result4;
      l4 = {l4[2:0], l4[3] ^ l4[2]};
    end
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    distinct = 0;
    for (int i = 0; i < 15; i++) begin
      if (!seen[res4[i]]) distinct++;
      seen[res4[i]] = 1'b1;
    end
    chk("w4_distinct", 32'(distinct), 32'd15);
    for (int i = 0; i < 15; i++) chk("w4_period", 32'(res4[i + 15]), 32'(res4[i]));
    @(negedge clk);
    en4 = 1'b0;
    ordy4 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
